// File: rtl/line_buffer_3row.sv
// ============================================================================
// Module   : line_buffer_3row
// Purpose  : Four-bank ring row buffer feeding 3-pixel vertical columns
//            (3 read rows plus 1 fill row) to a sliding-window consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buffer_3row #(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_WIDTH = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [BIT_DEPTH-1:0] pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 shift_buffer,
    output logic                 window_ready,
    output logic [BIT_DEPTH-1:0] out_l1,
    output logic [BIT_DEPTH-1:0] out_l2,
    output logic [BIT_DEPTH-1:0] out_l3,
    output logic                 out_valid,
    output logic                 row_done
);

    localparam int              C_CW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [C_CW-1:0] C_LAST_COL = C_CW'(IMG_WIDTH - 1);

    logic [BIT_DEPTH-1:0] r_mem [4][IMG_WIDTH];

    logic [1:0]           r_wr_bank;
    logic [C_CW-1:0]      r_wr_col;
    logic [1:0]           r_top_bank;
    logic [C_CW-1:0]      r_rd_col;
    logic [2:0]           r_full_rows;
    logic [BIT_DEPTH-1:0] r_out_l1;
    logic [BIT_DEPTH-1:0] r_out_l2;
    logic [BIT_DEPTH-1:0] r_out_l3;
    logic                 r_out_valid;
    logic                 r_row_done;

    logic       w_flush;
    logic       w_wr;
    logic       w_sh;
    logic       w_wr_row_end;
    logic       w_sh_row_end;
    logic [1:0] w_mid_bank;
    logic [1:0] w_bot_bank;

    assign w_flush      = rst | clear;
    assign pix_ready    = (r_full_rows != 3'd4);
    assign window_ready = (r_full_rows >= 3'd3);
    assign w_wr         = pix_valid & pix_ready;
    assign w_sh         = shift_buffer & window_ready;
    assign w_wr_row_end = w_wr & (r_wr_col == C_LAST_COL);
    assign w_sh_row_end = w_sh & (r_rd_col == C_LAST_COL);
    assign w_mid_bank   = r_top_bank + 2'd1;
    assign w_bot_bank   = r_top_bank + 2'd2;

    // Bank contents survive reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr && !w_flush) begin
            r_mem[r_wr_bank][r_wr_col] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wr_bank   <= 2'd0;
            r_wr_col    <= '0;
            r_top_bank  <= 2'd0;
            r_rd_col    <= '0;
            r_full_rows <= 3'd0;
            r_out_l1    <= '0;
            r_out_l2    <= '0;
            r_out_l3    <= '0;
            r_out_valid <= 1'b0;
            r_row_done  <= 1'b0;
        end else begin
            r_out_valid <= w_sh;
            r_row_done  <= w_sh_row_end;

            if (w_wr) begin
                if (w_wr_row_end) begin
                    r_wr_col  <= '0;
                    r_wr_bank <= r_wr_bank + 2'd1;
                end else begin
                    r_wr_col  <= r_wr_col + C_CW'(1);
                end
            end

            // The fill bank is never one of the three read banks, so a
            // same-cycle write cannot alias into a column being read.
            if (w_sh) begin
                r_out_l1 <= r_mem[r_top_bank][r_rd_col];
                r_out_l2 <= r_mem[w_mid_bank][r_rd_col];
                r_out_l3 <= r_mem[w_bot_bank][r_rd_col];
                if (w_sh_row_end) begin
                    r_rd_col   <= '0;
                    r_top_bank <= w_mid_bank;
                end else begin
                    r_rd_col   <= r_rd_col + C_CW'(1);
                end
            end

            case ({w_wr_row_end, w_sh_row_end})
                2'b10:   r_full_rows <= r_full_rows + 3'd1;
                2'b01:   r_full_rows <= r_full_rows - 3'd1;
                default: r_full_rows <= r_full_rows;
            endcase
        end
    end

    assign out_l1    = r_out_l1;
    assign out_l2    = r_out_l2;
    assign out_l3    = r_out_l3;
    assign out_valid = r_out_valid;
    assign row_done  = r_row_done;

endmodule

`default_nettype wire
